// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler sharing one byte-lane MAC between two requesters
module mac_sched #(
    parameter int N     = 127,
    parameter int LANES = (N + 1) / 8,
    parameter int CW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_req,
    input  logic [N:0]    i_a0,
    input  logic [N:0]    i_b0,
    input  logic [N:0]    i_a1,
    input  logic [N:0]    i_b1,
    output logic [1:0]    o_ack,
    output logic [7:0]    o_res_out,
    output logic          o_busy,
    output logic          o_gnt_id,
    output logic [N:0]    o_mac_a,
    output logic [N:0]    o_mac_b,
    output logic [CW-1:0] o_mac_cnt,
    output logic          o_mac_clr,
    output logic          o_mac_en,
    input  logic [7:0]    i_mac_res
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic          r_gnt;
    logic          r_last;
    logic          r_busy;
    logic          r_clr;
    logic          r_en;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_res;
    logic [N:0]    r_mac_a;
    logic [N:0]    r_mac_b;
    logic          w_gnt;

    // a lone request wins outright; a tie goes to the side that did not win last time
    assign w_gnt = (i_req == 2'b11) ? ~r_last : i_req[1];

    // operation sequencer: grant/latch, clear, step lanes, capture result, hold until released
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
            r_clr   <= 1'b0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_mac_a <= '0;
            r_mac_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (|i_req) begin
                    r_state <= S_CLR;
                    r_busy  <= 1'b1;
                    r_clr   <= 1'b1;
                    r_gnt   <= w_gnt;
                    r_last  <= w_gnt;
                    r_cnt   <= '0;
                    r_mac_a <= w_gnt ? i_a1 : i_a0;
                    r_mac_b <= w_gnt ? i_b1 : i_b0;
                end
                S_CLR: begin
                    r_state <= S_RUN;
                    r_clr   <= 1'b0;
                    r_en    <= 1'b1;
                end
                S_RUN: if (r_cnt == CW'(LANES - 1)) begin
                    r_state <= S_WAIT;
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_WAIT: begin
                    r_state <= S_DONE;
                    r_res   <= i_mac_res;
                end
                S_DONE: if (!i_req[r_gnt]) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ack follows the winner's request while in DONE so it drops together with req
    always_comb begin
        o_ack = (r_state == S_DONE && i_req[r_gnt]) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    assign o_res_out = r_res;
    assign o_busy    = r_busy;
    assign o_gnt_id  = r_gnt;
    assign o_mac_a   = r_mac_a;
    assign o_mac_b   = r_mac_b;
    assign o_mac_cnt = r_cnt;
    assign o_mac_clr = r_clr;
    assign o_mac_en  = r_en;
endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: directed bench for mac_sched with a behavioural byte-lane MAC
module tb_mac_sched;
    localparam int N  = 127;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    req   = 2'b00;
    logic [N:0]    a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]    ack;
    logic [7:0]    res_out;
    logic          busy, gnt_id;
    logic [N:0]    mac_a, mac_b;
    logic [CW-1:0] mac_cnt;
    logic          mac_clr, mac_en;
    logic [7:0]    mac_res;
    logic [15:0]   acc = '0;
    logic [15:0]   prod;
    int            vectors = 0, miscompares = 0;
    int            run_idx = 0;
    logic          prev_clr = 1'b0;

    always #5 clk = ~clk;

    mac_sched #(.N(N), .CW(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
        .o_ack(ack), .o_res_out(res_out), .o_busy(busy), .o_gnt_id(gnt_id),
        .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_cnt(mac_cnt),
        .o_mac_clr(mac_clr), .o_mac_en(mac_en), .i_mac_res(mac_res)
    );

    // MAC model: accumulates the high byte of each lane product; not reset, so only mac_clr clears it
    assign prod    = 16'(mac_a[mac_cnt*8 +: 8]) * 16'(mac_b[mac_cnt*8 +: 8]);
    assign mac_res = acc[11:4];
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else if (mac_en) acc <= acc + {8'h00, prod[15:8]};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one grant-to-ack operation started by the request just driven; checks CLR cycle, cycle 18 and cycle 19
    task automatic op(input logic [1:0] e_ack, input logic e_gnt, input logic [7:0] e_res, input logic [N:0] e_a);
        cycles(1);
        chk("clr_cycle", mac_clr, 1);
        chk("grant_id", gnt_id, e_gnt);
        chk("latched_a", mac_a, e_a);
        cycles(17);
        chk("ack_early", ack, 0);
        cycles(1);
        chk("ack", ack, e_ack);
        chk("res_out", res_out, e_res);
        chk("gnt_done", gnt_id, e_gnt);
    endtask

    // per-cycle protocol checks on the MAC interface
    always @(negedge clk) begin
        chk("clr_en_overlap", mac_clr & mac_en, 0);
        chk("clr_single", prev_clr & mac_clr, 0);
        chk("mac_cnt_seq", mac_cnt, mac_en ? run_idx : 0);
        chk("ack_onehot", ack == 2'b11, 0);
        run_idx  = mac_en ? run_idx + 1 : 0;
        prev_clr = mac_clr;
    end

    initial begin
        #1 rst_n = 1'b0;
        cycles(2);
        chk("rst_ack", ack, 0);
        chk("rst_res", res_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_cnt", mac_cnt, 0);
        chk("rst_mac_en", mac_en, 0);
        rst_n = 1'b1;

        a0 = {16{8'h10}}; b0 = {16{8'h10}}; req = 2'b01;
        cycles(1);
        chk("t1_clr", mac_clr, 1);
        chk("t1_busy", busy, 1);
        chk("t1_mac_a", mac_a, {16{8'h10}});
        a0 = '0; b0 = '0;
        cycles(17);
        chk("t1_ack18", ack, 0);
        cycles(1);
        chk("t1_ack19", ack, 2'b01);
        chk("t1_res", res_out, 8'h01);
        chk("t1_gnt", gnt_id, 0);
        req = 2'b00;
        cycles(1);
        chk("t1_idle", busy, 0);
        chk("t1_res_hold", res_out, 8'h01);

        a1 = {16{8'hFF}}; b1 = {16{8'hFF}}; a0 = {16{8'h33}}; req = 2'b10;
        op(2'b10, 1'b1, 8'hFE, {16{8'hFF}});
        cycles(3);
        chk("t2_ack_hold", ack, 2'b10);
        chk("t2_busy_hold", busy, 1);
        req = 2'b00;
        #1 chk("t2_ack_drop", ack, 0);
        cycles(1);
        chk("t2_idle", busy, 0);

        a0 = {16{8'h10}}; b0 = {16{8'h10}}; req = 2'b11;
        op(2'b01, 1'b0, 8'h01, a0);
        req = 2'b10; cycles(1);
        chk("t3_idle_a", busy, 0);
        req = 2'b11;
        op(2'b10, 1'b1, 8'hFE, a1);
        req = 2'b01; cycles(1);
        req = 2'b11;
        op(2'b01, 1'b0, 8'h01, a0);
        req = 2'b10; cycles(1);
        req = 2'b11;
        op(2'b10, 1'b1, 8'hFE, a1);
        req = 2'b00; cycles(1);

        a0 = {16{8'hFF}}; b0 = {16{8'hFF}}; req = 2'b01;
        cycles(9);
        chk("t4_cnt7", mac_cnt, 7);
        chk("t4_en", mac_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_ack", ack, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_res", res_out, 0);
        chk("t4_rst_cnt", mac_cnt, 0);
        chk("t4_rst_en", mac_en, 0);
        chk("t4_rst_mac_a", mac_a, 0);
        cycles(1);
        rst_n = 1'b1;
        op(2'b01, 1'b0, 8'hFE, a0);
        req = 2'b00; cycles(1);

        a0 = {16{8'h10}}; b0 = {16{8'h10}}; req = 2'b01;
        cycles(5);
        req = 2'b00;
        cycles(13);
        chk("t5_busy18", busy, 1);
        chk("t5_ack18", ack, 0);
        cycles(1);
        chk("t5_ack19", ack, 0);
        chk("t5_busy19", busy, 1);
        chk("t5_res", res_out, 8'h01);
        cycles(1);
        chk("t5_idle", busy, 0);
        chk("t5_ack20", ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
